// File: rtl/gf_pow_mult_seq.sv
// Multi-lane sequential GF(2^8) multiplier by x^k or x^-k (poly 11B).
// Ports: clk, reset_n (sync, active-low), in_valid/in_ready/in_inv/in_k/in_a
//        request side; out_valid/out_ready/out_y result side; busy.
module gf_pow_mult_seq #(
    parameter int LANES = 4,
    parameter int MAXP  = 15,
    localparam int PW   = $clog2(MAXP + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [PW-1:0]      in_k,
    input  logic [8*LANES-1:0] in_a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_y,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [8*LANES-1:0] r_y;
    logic [PW-1:0]      r_count;
    logic               r_mode;
    logic [8*LANES-1:0] w_step;

    // One multiply-by-x (or by x^-1) per lane per cycle.
    // x^-1 = 8D: shift right, and fold the dropped bit back in as 8D.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] w_b;
        logic [7:0] w_fwd;
        logic [7:0] w_inv;
        assign w_b   = r_y[8*g +: 8];
        assign w_fwd = {w_b[6:0], 1'b0} ^ (w_b[7] ? 8'h1B : 8'h00);
        assign w_inv = {1'b0, w_b[7:1]} ^ (w_b[0] ? 8'h8D : 8'h00);
        assign w_step[8*g +: 8] = r_mode ? w_inv : w_fwd;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = (in_k == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == PW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_y     <= '0;
            r_count <= '0;
            r_mode  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_y     <= in_a;
                        r_count <= in_k;
                        r_mode  <= in_inv;
                    end
                end
                S_RUN: begin
                    r_y     <= w_step;
                    r_count <= r_count - PW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Ready is masked by reset so nothing is taken while reset is held.
    assign in_ready  = reset_n && (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_y     = r_y;

endmodule

// File: tb/tb_gf_pow_mult_seq.sv
// Directed bench for gf_pow_mult_seq with a result scoreboard.
// Expected bytes come from a generic GF(2^8) multiply model.
module tb_gf_pow_mult_seq;

    localparam int LANES = 4;
    localparam int MAXP  = 15;
    localparam int PW    = $clog2(MAXP + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_inv;
    logic [PW-1:0]     in_k;
    logic [8*LANES-1:0] in_a;
    logic              out_valid;
    logic              out_ready;
    logic [8*LANES-1:0] out_y;
    logic              busy;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] exp_q[$];
    int          k_q[$];

    gf_pow_mult_seq #(.LANES(LANES), .MAXP(MAXP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_k      (in_k),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input int k, input bit inv);
        logic [7:0]  c = 8'h01;
        logic [31:0] r;
        for (int i = 0; i < k; i++) c = gfmul(c, inv ? 8'h8D : 8'h02);
        for (int l = 0; l < LANES; l++) r[8*l +: 8] = gfmul(a[8*l +: 8], c);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic start(input logic [31:0] a, input int k, input bit inv);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_k     = PW'(k);
        in_inv   = inv;
        @(posedge clk);
        exp_q.push_back(model(a, k, inv));
        k_q.push_back(k);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_k     = PW'($urandom);
        in_inv   = 1'($urandom);
    endtask

    task automatic wait_result(input string tag, output logic [31:0] y);
        int lat = 1;
        int k;
        logic [31:0] e;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        k = k_q.pop_front();
        chk({tag, "_lat"}, 32'(lat), 32'(k + 1));
        chk({tag, "_y"}, out_y, e);
        y = out_y;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input string tag, input logic [31:0] a, input int k,
                       input bit inv, output logic [31:0] y);
        start(a, k, inv);
        wait_result(tag, y);
    endtask

    logic [31:0] y, a0, held;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_k      = '0;
        in_a      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_y", out_y, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        req("f57k1", 32'h0000_0057, 1, 1'b0, y);
        chk("f57k1_lit", y[7:0], 32'hAE);
        req("f57k2", 32'h0000_0057, 2, 1'b0, y);
        chk("f57k2_lit", y[7:0], 32'h47);
        req("f80k1", 32'h0000_0080, 1, 1'b0, y);
        chk("f80k1_lit", y[7:0], 32'h1B);
        req("i01k1", 32'h0000_0001, 1, 1'b1, y);
        chk("i01k1_lit", y[7:0], 32'h8D);
        req("i02k1", 32'h0000_0002, 1, 1'b1, y);
        chk("i02k1_lit", y[7:0], 32'h01);
        req("k0", 32'hDEAD_BEEF, 0, 1'b0, y);
        chk("k0_lit", y, 32'hDEAD_BEEF);
        req("mixed", 32'h8001_FF57, 7, 1'b1, y);

        for (int t = 0; t < 3; t++) begin
            a0 = $urandom;
            req("rt_fwd", a0, MAXP, 1'b0, y);
            req("rt_inv", y, MAXP, 1'b1, y);
            chk("rt_orig", y, a0);
        end

        out_ready = 1'b0;
        start(32'h1234_5678, 3, 1'b0);
        wait_result("bp", held);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'hCAFE_F00D;
        in_k     = '0;
        in_inv   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_y", out_y, held);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_drain_y", out_y, held);
        chk("bp_drain_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        exp_q.push_back(model(32'hCAFE_F00D, 0, 1'b0));
        k_q.push_back(0);
        #1;
        in_valid = 1'b0;
        wait_result("bp_next", y);

        start(32'hA5A5_3C3C, 10, 1'b0);
        void'(exp_q.pop_back());
        void'(k_q.pop_back());
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_y", out_y, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("mrst_quiet", {31'd0, out_valid}, 32'd0);
        end
        req("post_rst", 32'h0102_0408, 4, 1'b0, y);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
